mux_sweep_ctrl: RTL and testbench

MUX_SWEEP_CTRL -- requirements
Module: mux_sweep_ctrl

---
 rtl/mux_sweep_ctrl.sv | 125 ++++++++++++
 tb/tb_mux_sweep_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_sweep_ctrl.sv
// Exhaustive 4:1 mux sweep controller: drives all 16 {s1,s0,a,b} vectors,
// holds each for HOLD cycles, then samples y into result[vector].
module mux_sweep_ctrl #(
    parameter int unsigned HOLD = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        y,
    output logic        a,
    output logic        b,
    output logic        s1,
    output logic        s0,
    output logic [3:0]  vec_idx,
    output logic        busy,
    output logic        done,
    output logic [15:0] result
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_e;

    localparam logic [7:0] RELOAD = 8'(HOLD - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  vec_q, vec_d;
    logic [3:0]  drv_q, drv_d;
    logic [15:0] result_q, result_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            vec_q    <= '0;
            drv_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            vec_q    <= vec_d;
            drv_q    <= drv_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Abort takes priority over both start and the SAMPLE capture.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        vec_d    = vec_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d  = DRIVE;
                    vec_d    = '0;
                    cnt_d    = RELOAD;
                    result_d = '0;
                end
            end
            DRIVE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_q == 8'd0) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            SAMPLE: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    result_d[vec_q] = y;
                    if (vec_q == 4'd15) begin
                        state_d = DONE;
                    end else begin
                        state_d = DRIVE;
                        vec_d   = vec_q + 4'd1;
                        cnt_d   = RELOAD;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == IDLE) begin
            vec_d = '0;
            cnt_d = '0;
        end

        // Outputs are computed from the next state so they are registered yet aligned with it.
        drv_d  = (state_d == IDLE) ? 4'd0 : vec_d;
        busy_d = (state_d == DRIVE) || (state_d == SAMPLE);
        done_d = (state_d == DONE);
    end

    assign s1      = drv_q[3];
    assign s0      = drv_q[2];
    assign a       = drv_q[1];
    assign b       = drv_q[0];
    assign vec_idx = vec_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign result  = result_q;

endmodule

// File: tb/tb_mux_sweep_ctrl.sv
// Bench for mux_sweep_ctrl: one instance at HOLD=2 and one at HOLD=1, with y
// produced by a loopback/lookup model and all timing derived from the sweep rules.
module tb_mux_sweep_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        sel;
    int          mode;
    logic [15:0] rtab;
    int          errors;
    int          checks;

    logic        a2, b2, s12, s02, busy2, done2, y2;
    logic [3:0]  vec2;
    logic [15:0] res2;
    logic        a1, b1, s11, s01, busy1, done1, y1;
    logic [3:0]  vec1;
    logic [15:0] res1;

    logic [3:0]  oDrv;
    logic [3:0]  oVec;
    logic        oBusy, oDone;
    logic [15:0] oRes;

    // y as seen by a mux whose response is defined per {s1,s0,a,b} vector.
    function automatic logic yModel(input int m, input logic [15:0] tab, input logic [3:0] v);
        case (m)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return v[1];
            3:       return v[0];
            4:       return v[3];
            default: return tab[v];
        endcase
    endfunction

    function automatic logic [15:0] expRes(input int m, input logic [15:0] tab);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[i] = yModel(m, tab, 4'(i));
        return r;
    endfunction

    function automatic logic [15:0] lowMask(input int v);
        logic [16:0] one;
        one = 17'h1;
        return 16'((one << v) - 17'h1);
    endfunction

    assign y2 = yModel(mode, rtab, {s12, s02, a2, b2});
    assign y1 = yModel(mode, rtab, {s11, s01, a1, b1});

    mux_sweep_ctrl #(.HOLD(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start & ~sel), .abort(abort & ~sel), .y(y2),
        .a(a2), .b(b2), .s1(s12), .s0(s02), .vec_idx(vec2),
        .busy(busy2), .done(done2), .result(res2)
    );

    mux_sweep_ctrl #(.HOLD(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start & sel), .abort(abort & sel), .y(y1),
        .a(a1), .b(b1), .s1(s11), .s0(s01), .vec_idx(vec1),
        .busy(busy1), .done(done1), .result(res1)
    );

    assign oDrv  = sel ? {s11, s01, a1, b1} : {s12, s02, a2, b2};
    assign oVec  = sel ? vec1 : vec2;
    assign oBusy = sel ? busy1 : busy2;
    assign oDone = sel ? done1 : done2;
    assign oRes  = sel ? res1 : res2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so a wedged DUT still ends the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic checkIdle(input string tag, input logic [15:0] expResult);
        checkOutput({tag, ".busy"}, 32'(oBusy), 0);
        checkOutput({tag, ".done"}, 32'(oDone), 0);
        checkOutput({tag, ".vec"}, 32'(oVec), 0);
        checkOutput({tag, ".drv"}, 32'(oDrv), 0);
        checkOutput({tag, ".result"}, 32'(oRes), 32'(expResult));
    endtask

    // Runs one sweep from a negedge; optional abort at (abortVec, abortOff cycles
    // into that vector) and optional ignored start while busy in restartVec.
    task automatic applyStimulus(input int h, input logic [15:0] exp, input int abortVec,
                                 input int abortOff, input int restartVec);
        int per;
        int total;
        int v;
        per   = h + 1;
        total = 16 * per;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j <= total; j++) begin
            if (j < total) begin
                v = j / per;
                checkOutput("sweep.busy", 32'(oBusy), 1);
                checkOutput("sweep.done", 32'(oDone), 0);
                checkOutput("sweep.vec", 32'(oVec), 32'(v));
                checkOutput("sweep.drv", 32'(oDrv), 32'(v));
                checkOutput("sweep.partial", 32'(oRes), 32'(exp & lowMask(v)));
                if (v == abortVec && j == v * per + abortOff) begin
                    abort = 1'b1;
                    start = 1'b0;
                    @(negedge clk);
                    abort = 1'b0;
                    checkIdle("abort", exp & lowMask(v));
                    for (int k = 0; k < 3; k++) begin
                        @(negedge clk);
                        checkIdle("postAbort", exp & lowMask(v));
                    end
                    return;
                end
                start = (v == restartVec && j == v * per + 1);
            end else begin
                checkOutput("end.done", 32'(oDone), 1);
                checkOutput("end.busy", 32'(oBusy), 0);
                checkOutput("end.result", 32'(oRes), 32'(exp));
            end
            @(negedge clk);
        end
        start = 1'b0;
        checkIdle("afterDone", exp);
    endtask

    initial begin
        int h;
        int av;
        int ao;
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        sel    = 1'b0;
        mode   = 1;
        rtab   = '0;

        #3;
        checkIdle("reset", 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkIdle("released", 16'h0000);

        $display("[TB] full sweep y=1, y=a, y=s1 at HOLD=2");
        mode = 1;
        applyStimulus(2, 16'hFFFF, -1, 0, -1);
        mode = 2;
        applyStimulus(2, 16'hCCCC, -1, 0, -1);
        mode = 4;
        applyStimulus(2, 16'hFF00, -1, 0, -1);

        $display("[TB] ignored restart and aborts");
        mode = 1;
        applyStimulus(2, 16'hFFFF, 5, 0, 3);
        applyStimulus(2, 16'hFFFF, 4, 2, -1);

        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        checkIdle("startAbortIdle", 16'h000F);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkIdle("abortIdle", 16'h000F);

        $display("[TB] reset mid-sweep");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7 * 3) @(negedge clk);
        checkOutput("preReset.vec", 32'(oVec), 7);
        #2 rst_n = 1'b0;
        #1;
        checkIdle("asyncReset", 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            checkOutput("postReset.done", 32'(oDone), 0);
            checkOutput("postReset.busy", 32'(oBusy), 0);
        end
        checkOutput("postReset.result", 32'(oRes), 0);

        $display("[TB] HOLD=1 back-to-back sweeps");
        sel  = 1'b1;
        mode = 3;
        applyStimulus(1, 16'hAAAA, -1, 0, -1);
        mode = 1;
        applyStimulus(1, 16'hFFFF, -1, 0, -1);

        $display("[TB] randomized lookup-table sweeps");
        for (int n = 0; n < 8; n++) begin
            mode = 5;
            rtab = 16'($urandom);
            sel  = 1'($urandom_range(0, 1));
            h    = sel ? 1 : 2;
            if ($urandom_range(0, 2) == 0) begin
                av = $urandom_range(0, 15);
                ao = $urandom_range(0, h);
            end else begin
                av = -1;
                ao = 0;
            end
            @(negedge clk);
            applyStimulus(h, expRes(mode, rtab), av, ao, $urandom_range(0, 15));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
